// File: rtl/count_disp_pkg.sv
// Shared types and constants for the count display tile: FSM states,
// scan defaults, digit-select codes, blank glyph and the BCD add-3 helper.
package count_disp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_e;

   localparam int unsigned SCAN_DIV_DEFAULT = 1024;

   // Eight shifts are counted 0..7, so three bits are enough.
   localparam int BIT_CNT_W = 3;

   localparam logic [2:0] SEL_D0 = 3'b001;  // units / low nibble
   localparam logic [2:0] SEL_D1 = 3'b010;  // tens / high nibble
   localparam logic [2:0] SEL_D2 = 3'b100;  // hundreds

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Double-dabble correction: a BCD nibble of 5 or more overflows past 9
   // once shifted, so it is pre-biased by 3 before the shift.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to common-cathode 7-segment glyph, bit order {g,f,e,d,c,b,a}.
module seg7_decode (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Standard glyph table for 0-9 and A, b, C, d, E, F.
   always_comb begin
      unique case (nibble_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         default: seg_o = 7'h71;
      endcase
   end

endmodule

// File: rtl/tt_um_count_display_shivam.sv
// Count display tile: samples ui_in on a rising load strobe, converts it to
// BCD with an 8-cycle shift-and-add-3 engine, and scans three multiplexed
// 7-segment digits in decimal or hex. Define COUNT_DISP_LZB_EN to enable
// leading-zero blanking.
module tt_um_count_display_shivam
   import count_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

   state_e                 state_q, state_d;
   logic                   strb_prev_q;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             bin_q, bin_d;
   logic [9:0]             bcd_q, bcd_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [1:0]             hund_q, hund_d;
   logic [3:0]             tens_q, tens_d;
   logic [3:0]             units_q, units_d;
   logic [7:0]             disp_bin_q, disp_bin_d;
   logic [15:0]            presc_q;
   logic [1:0]             digit_idx_q;
   logic [6:0]             seg_q;
   logic [2:0]             sel_q;

   logic       load;
   logic       hex_mode;
   logic [9:0] bcd_adj;
   logic [9:0] bcd_shift;
   logic [3:0] nib;
   logic       blank;
   logic [2:0] sel_d;
   logic [6:0] dec_seg;

   // Enable and the upper uio bits carry no function on this tile.
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in[7:3]};

   assign hex_mode = uio_in[1];
   assign load     = uio_in[0] & ~strb_prev_q & (state_q == IDLE) & ~uio_in[2];

   // One conversion step: bias each decimal nibble, then shift the next binary bit in.
   assign bcd_adj   = {bcd_q[9:8], add3(bcd_q[7:4]), add3(bcd_q[3:0])};
   assign bcd_shift = {bcd_adj[8:0], shift_q[7]};

   // FSM next state and conversion datapath.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d    = state_q;
      shift_d    = shift_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      bit_cnt_d  = bit_cnt_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      units_d    = units_q;
      disp_bin_d = disp_bin_q;
      unique case (state_q)
         IDLE: begin
            if (load) begin
               shift_d   = ui_in;
               bin_d     = ui_in;
               bcd_d     = '0;
               bit_cnt_d = '0;
               state_d   = CONV;
            end
         end
         CONV: begin
            shift_d   = {shift_q[6:0], 1'b0};
            bcd_d     = bcd_shift;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == {BIT_CNT_W{1'b1}}) begin
               hund_d     = bcd_shift[9:8];
               tens_d     = bcd_shift[7:4];
               units_d    = bcd_shift[3:0];
               disp_bin_d = bin_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, strobe history and conversion registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         strb_prev_q <= 1'b0;
         shift_q     <= '0;
         bin_q       <= '0;
         bcd_q       <= '0;
         bit_cnt_q   <= '0;
         hund_q      <= '0;
         tens_q      <= '0;
         units_q     <= '0;
         disp_bin_q  <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q     <= state_d;
         strb_prev_q <= uio_in[0];
         shift_q     <= shift_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         bit_cnt_q   <= bit_cnt_d;
         hund_q      <= hund_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         disp_bin_q  <= disp_bin_d;
      end
   end

   // Pick the nibble, blanking and select for the digit currently scanned.
   always_comb begin
      nib   = 4'h0;
      blank = 1'b0;
      sel_d = SEL_D0;
      unique case (digit_idx_q)
         2'd0: begin
            sel_d = SEL_D0;
            nib   = hex_mode ? disp_bin_q[3:0] : units_q;
         end
         2'd1: begin
            sel_d = SEL_D1;
            if (hex_mode) begin
               nib = disp_bin_q[7:4];
`ifdef COUNT_DISP_LZB_EN
               blank = (disp_bin_q[7:4] == 4'h0);
`endif
            end else begin
               nib = tens_q;
`ifdef COUNT_DISP_LZB_EN
               blank = (hund_q == 2'd0) && (tens_q == 4'h0);
`endif
            end
         end
         default: begin
            sel_d = SEL_D2;
            nib   = {2'b00, hund_q};
            if (hex_mode) begin
               blank = 1'b1;
            end else begin
`ifdef COUNT_DISP_LZB_EN
               blank = (hund_q == 2'd0);
`endif
            end
         end
      endcase
   end

   seg7_decode u_dec (
      .nibble_i (nib),
      .seg_o    (dec_seg)
   );

   // Prescaler, digit rotation and the segment/select output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         digit_idx_q <= '0;
         seg_q       <= '0;
         sel_q       <= '0;
      end else begin
         if (presc_q == PRESC_MAX) begin
            presc_q     <= '0;
            digit_idx_q <= (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
         end else begin
            presc_q <= presc_q + 16'd1;
         end
         seg_q <= blank ? SEG_BLANK : dec_seg;
         sel_q <= sel_d;
      end
   end

   assign uo_out  = {(state_q == CONV), seg_q};
   assign uio_out = {1'b0, sel_q, 4'b0000};
   assign uio_oe  = 8'b0111_0000;

endmodule
